// File: rtl/vec_lsu_pkg.sv
// Shared types, constants and lane helpers for the vector load/store sequencer.
package vec_lsu_pkg;

   localparam int VEC_WIDTH = 24;
   localparam int VEC_LANES = 8;
   localparam logic [3:0] MEM_WE_STORE = 4'b0100;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } lsu_state_t;

   function automatic logic [VEC_WIDTH-1:0] lane_get(
      input logic [VEC_LANES*VEC_WIDTH-1:0] vec,
      input int unsigned                    lane
   );
      return vec[lane*VEC_WIDTH +: VEC_WIDTH];
   endfunction

   function automatic logic [VEC_LANES*VEC_WIDTH-1:0] lane_set(
      input logic [VEC_LANES*VEC_WIDTH-1:0] vec,
      input int unsigned                    lane,
      input logic [VEC_WIDTH-1:0]           val
   );
      logic [VEC_LANES*VEC_WIDTH-1:0] r;
      r = vec;
      r[lane*VEC_WIDTH +: VEC_WIDTH] = val;
      return r;
   endfunction

endpackage

// File: rtl/vec_lsu_agen.sv
// Element address/index generator: loads base on accept, steps by a two's complement
// stride each beat and flags the final element of the request.
module vec_lsu_agen
   import vec_lsu_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int LEN_W = $clog2(VEC_LANES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] base_i,
   input  logic [WIDTH-1:0] stride_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [WIDTH-1:0] addr_o,
   output logic [LEN_W-1:0] idx_o,
   output logic             last_o
);

   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] stride_q, stride_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;

   // Address arithmetic is plain modulo 2^WIDTH, so negative strides wrap naturally.
   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      idx_d    = idx_q;
      len_d    = len_q;
      if (load_i) begin
         addr_d   = base_i;
         stride_d = stride_i;
         idx_d    = '0;
         len_d    = len_i;
      end else if (step_i) begin
         addr_d = addr_q + stride_q;
         idx_d  = idx_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         stride_q <= '0;
         idx_q    <= '0;
         len_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
      end
   end

   assign addr_o = addr_q;
   assign idx_o  = idx_q;
   assign last_o = (idx_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer: serialises one strided vector request into per-element dmem beats.
// Define VEC_LSU_BOUNDS_CHECK_EN to suppress beats at addr >= AMOUNT and report them on resp_err.
module vec_lsu
   import vec_lsu_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int LANES = VEC_LANES
`ifdef VEC_LSU_BOUNDS_CHECK_EN
   ,
   parameter int AMOUNT = 90000
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_store,
   input  logic [WIDTH-1:0]              req_base,
   input  logic [WIDTH-1:0]              req_stride,
   input  logic [$clog2(LANES+1)-1:0]    req_len,
   input  logic [LANES*WIDTH-1:0]        req_wdata,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [LANES*WIDTH-1:0]        resp_rdata,
   output logic [3:0]                    mem_we,
   output logic [WIDTH-1:0]              mem_a,
   output logic [WIDTH-1:0]              mem_wd,
   input  logic [WIDTH-1:0]              mem_rd,
   output logic                          busy
`ifdef VEC_LSU_BOUNDS_CHECK_EN
   ,
   output logic                          resp_err
`endif
);

   localparam int LEN_W = $clog2(LANES + 1);

   lsu_state_t             state_q, state_d;
   logic                   store_q;
   logic [LANES*WIDTH-1:0] wdata_q;
   logic [LANES*WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0]       mem_a_q;
   logic [WIDTH-1:0]       mem_wd_q;

   logic [WIDTH-1:0]       addr;
   logic [LEN_W-1:0]       idx;
   logic                   last_beat;
   logic                   accept;
   logic                   beat;
   logic                   beat_ok;
   logic [WIDTH-1:0]       beat_wd;

   assign accept  = req_valid && (state_q == IDLE);
   assign beat    = (state_q == RUN);
   assign beat_wd = lane_get(wdata_q, 32'(idx));

`ifdef VEC_LSU_BOUNDS_CHECK_EN
   localparam logic [WIDTH:0] AMOUNT_LIM = (WIDTH+1)'(AMOUNT);
   logic err_q;

   assign beat_ok = ({1'b0, addr} < AMOUNT_LIM);

   // Sticky until the next request is accepted, so the consumer sees it with resp_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (beat && !beat_ok) begin
         err_q <= 1'b1;
      end
   end

   assign resp_err = err_q;
`else
   assign beat_ok = 1'b1;
`endif

   vec_lsu_agen #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_agen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept),
      .step_i   (beat),
      .base_i   (req_base),
      .stride_i (req_stride),
      .len_i    (req_len),
      .addr_o   (addr),
      .idx_o    (idx),
      .last_o   (last_beat)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = (req_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_beat) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory strobes are combinational from state so an async reset kills mem_we at once.
   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == DONE);
      busy       = (state_q != IDLE);
      resp_rdata = rdata_q;
      mem_we     = '0;
      mem_a      = mem_a_q;
      mem_wd     = mem_wd_q;
      if (beat) begin
         mem_a  = addr;
         mem_wd = beat_wd;
         if (store_q && beat_ok) begin
            mem_we = MEM_WE_STORE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            store_q <= req_store;
            wdata_q <= req_wdata;
            if (!req_store) begin
               rdata_q <= '0;
            end
         end
         if (beat) begin
            mem_a_q  <= addr;
            mem_wd_q <= beat_wd;
            if (!store_q) begin
               rdata_q <= lane_set(rdata_q, 32'(idx), beat_ok ? mem_rd : '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_lsu.sv
// Directed self-checking bench for vec_lsu against a small 4096-word dmem model (mem[k]=k).
`timescale 1ns/1ps
module tb_vec_lsu;

   localparam int W  = 24;
   localparam int L  = 8;
   localparam int LW = 4;
   localparam int VB = L*W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_store;
   logic [W-1:0]  req_base;
   logic [W-1:0]  req_stride;
   logic [LW-1:0] req_len;
   logic [VB-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [VB-1:0] resp_rdata;
   logic [3:0]    mem_we;
   logic [W-1:0]  mem_a;
   logic [W-1:0]  mem_wd;
   logic [W-1:0]  mem_rd;
   logic          busy;
`ifdef VEC_LSU_BOUNDS_CHECK_EN
   logic          resp_err;
`endif

   int checks = 0;
   int errors = 0;
   int weTotal = 0;
   int weStart = 0;
   int logStart = 0;
   int lat = 0;
   logic [W-1:0]  addrLog[$];
   logic [W-1:0]  dmem [0:4095];
   logic [VB-1:0] exp;
   logic [VB-1:0] held;

   always #5 clk = ~clk;

   vec_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_base   (req_base),
      .req_stride (req_stride),
      .req_len    (req_len),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd),
      .busy       (busy)
`ifdef VEC_LSU_BOUNDS_CHECK_EN
      ,
      .resp_err   (resp_err)
`endif
   );

   // Index 4095 stands in for address 24'hFFFFFF so the wrap test reads back the full address.
   assign mem_rd = dmem[mem_a[11:0]];

   always @(posedge clk) begin
      if (mem_we == 4'b0100) begin
         dmem[mem_a[11:0]] <= mem_wd;
      end
   end

   always @(negedge clk) begin
      if (mem_we != 4'b0000) weTotal <= weTotal + 1;
      if (busy && !resp_valid) addrLog.push_back(mem_a);
   end

   task automatic checkOutput(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [W-1:0] base, input logic [W-1:0] stride,
                                input logic [LW-1:0] len, input logic [VB-1:0] wd);
      @(negedge clk);
      logStart   = addrLog.size();
      weStart    = weTotal;
      req_store  = st;
      req_base   = base;
      req_stride = stride;
      req_len    = len;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic waitResp();
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finishResp(input string tag);
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, VB'(resp_valid), VB'(1'b0));
      checkOutput({tag, "_ready_back"}, VB'(req_ready), VB'(1'b1));
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_base   = '0;
      req_stride = '0;
      req_len    = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      for (int k = 0; k < 4096; k++) dmem[k] <= 24'(k);
      dmem[4095] <= 24'hFFFFFF;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", VB'(req_ready), VB'(1'b1));
      checkOutput("rst_resp_valid", VB'(resp_valid), VB'(1'b0));
      checkOutput("rst_rdata", resp_rdata, '0);
      checkOutput("rst_mem_we", VB'(mem_we), VB'(4'b0000));
      checkOutput("rst_mem_a", VB'(mem_a), VB'(24'h0));
      checkOutput("rst_mem_wd", VB'(mem_wd), VB'(24'h0));
      checkOutput("rst_busy", VB'(busy), VB'(1'b0));
      rst_n = 1'b1;

      $display("[TB] step 1: load base=10 stride=1 len=4");
      applyStimulus(1'b0, 24'd10, 24'd1, 4'd4, '0);
      waitResp();
      checkOutput("t1_latency", VB'(lat), VB'(5));
      exp = '0;
      exp[0*W +: W] = 24'd10;
      exp[1*W +: W] = 24'd11;
      exp[2*W +: W] = 24'd12;
      exp[3*W +: W] = 24'd13;
      checkOutput("t1_rdata", resp_rdata, exp);
      checkOutput("t1_beats", VB'(addrLog.size() - logStart), VB'(4));
      checkOutput("t1_addr3", VB'(addrLog[logStart+3]), VB'(24'd13));
      checkOutput("t1_no_we", VB'(weTotal - weStart), VB'(0));
      finishResp("t1");

      $display("[TB] step 2: store base=100 stride=300 len=3");
      exp = '0;
      exp[0*W +: W] = 24'hABCDEF;
      exp[1*W +: W] = 24'h123456;
      exp[2*W +: W] = 24'h0F0F0F;
      for (int i = 3; i < L; i++) exp[i*W +: W] = 24'hDEAD00 + 24'(i);
      applyStimulus(1'b1, 24'd100, 24'd300, 4'd3, exp);
      waitResp();
      checkOutput("t2_latency", VB'(lat), VB'(4));
      checkOutput("t2_we_cycles", VB'(weTotal - weStart), VB'(3));
      finishResp("t2");
      checkOutput("t2_mem100", VB'(dmem[100]), VB'(24'hABCDEF));
      checkOutput("t2_mem400", VB'(dmem[400]), VB'(24'h123456));
      checkOutput("t2_mem700", VB'(dmem[700]), VB'(24'h0F0F0F));
      checkOutput("t2_mem1000_untouched", VB'(dmem[1000]), VB'(24'd1000));
      checkOutput("t2_mem_a_hold", VB'(mem_a), VB'(24'd700));

      $display("[TB] step 3: zero-length load");
      applyStimulus(1'b0, 24'd50, 24'd1, 4'd0, '0);
      waitResp();
      checkOutput("t3_latency", VB'(lat), VB'(1));
      checkOutput("t3_rdata_clear", resp_rdata, '0);
      checkOutput("t3_no_we", VB'(weTotal - weStart), VB'(0));
      checkOutput("t3_no_beats", VB'(addrLog.size() - logStart), VB'(0));
      finishResp("t3");

      $display("[TB] step 4: response back-pressure");
      applyStimulus(1'b0, 24'd20, 24'd2, 4'd2, '0);
      waitResp();
      exp = '0;
      exp[0*W +: W] = 24'd20;
      exp[1*W +: W] = 24'd22;
      checkOutput("t4_rdata", resp_rdata, exp);
      weStart    = weTotal;
      req_store  = 1'b1;
      req_base   = 24'd3000;
      req_stride = 24'd1;
      req_len    = 4'd2;
      req_wdata  = {L{24'h777777}};
      req_valid  = 1'b1;
      held       = resp_rdata;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("t4_hold_valid", VB'(resp_valid), VB'(1'b1));
         checkOutput("t4_hold_rdata", resp_rdata, exp);
         checkOutput("t4_hold_no_ready", VB'(req_ready), VB'(1'b0));
      end
      req_valid = 1'b0;
      finishResp("t4");
      checkOutput("t4_req_ignored", VB'(weTotal - weStart), VB'(0));
      checkOutput("t4_idle", VB'(busy), VB'(1'b0));
      checkOutput("t4_mem3000", VB'(dmem[3000]), VB'(24'd3000));

      $display("[TB] step 5: negative stride wrap");
      applyStimulus(1'b0, 24'd1, 24'hFFFFFF, 4'd3, '0);
      waitResp();
      checkOutput("t5_latency", VB'(lat), VB'(4));
      checkOutput("t5_addr0", VB'(addrLog[logStart+0]), VB'(24'd1));
      checkOutput("t5_addr1", VB'(addrLog[logStart+1]), VB'(24'd0));
      checkOutput("t5_addr2", VB'(addrLog[logStart+2]), VB'(24'hFFFFFF));
      exp = '0;
      exp[0*W +: W] = 24'd1;
      exp[1*W +: W] = 24'd0;
`ifdef VEC_LSU_BOUNDS_CHECK_EN
      exp[2*W +: W] = 24'd0;
      checkOutput("t5_err", VB'(resp_err), VB'(1'b1));
`else
      exp[2*W +: W] = 24'hFFFFFF;
`endif
      checkOutput("t5_rdata", resp_rdata, exp);
      finishResp("t5");
`ifdef VEC_LSU_BOUNDS_CHECK_EN
      applyStimulus(1'b0, 24'd5, 24'd1, 4'd0, '0);
      waitResp();
      checkOutput("t5_err_cleared", VB'(resp_err), VB'(1'b0));
      finishResp("t5b");
`endif

      $display("[TB] step 6: reset during store beat 2");
      exp = '0;
      for (int i = 0; i < L; i++) exp[i*W +: W] = 24'h111111 * 24'(i + 1);
      applyStimulus(1'b1, 24'd200, 24'd5, 4'd8, exp);
      @(negedge clk);
      @(negedge clk);
      checkOutput("t6_beat2_we", VB'(mem_we), VB'(4'b0100));
      checkOutput("t6_beat2_addr", VB'(mem_a), VB'(24'd210));
      rst_n = 1'b0;
      #1;
      checkOutput("t6_we_drop", VB'(mem_we), VB'(4'b0000));
      checkOutput("t6_busy_drop", VB'(busy), VB'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_idle", VB'(req_ready), VB'(1'b1));
      checkOutput("t6_mem200", VB'(dmem[200]), VB'(24'h111111));
      checkOutput("t6_mem205", VB'(dmem[205]), VB'(24'h222222));
      checkOutput("t6_mem210", VB'(dmem[210]), VB'(24'd210));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
